// File: rtl/svreal_arb_pkg.sv
// Shared helpers for the svreal multiplier arbiter: id width, alignment
// shift between fixed-point exponents and saturation bounds.
package svreal_arb_pkg;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Right-shift amount taking a product at exp_a+exp_b onto exp_o.
  // Positive means shift right (floor), negative means shift left.
  function automatic int align_shift(input int exp_a, input int exp_b, input int exp_o);
    return exp_o - (exp_a + exp_b);
  endfunction

  // Largest representable signed value of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest representable signed value of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/svreal_mul_arbiter_rr.sv
// Combinational round-robin picker: first active request after the pointer,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter
  import svreal_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_valid
);

  // Walk priorities ptr+1, ptr+2, ... and take the first active request.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_valid && req[i] && (i == ((int'(ptr) + k) % N))) begin
          grant[i]    = 1'b1;
          grant_idx   = IDW'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/svreal_mul_arbiter.sv
// One pipelined svreal fixed-point multiplier shared by N_REQ requesters.
// Round-robin arbitration in front, two register stages (operands, aligned
// product), tagged valid/ready result stream at the back.
// Build option: define SVREAL_MUL_ARB_SAT_EN to saturate the narrowed result
// instead of wrapping it.
module svreal_mul_arbiter
  import svreal_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = 16,
  parameter int EXP_A   = -8,
  parameter int WIDTH_B = 16,
  parameter int EXP_B   = -9,
  parameter int WIDTH_O = 18,
  parameter int EXP_O   = -10,
  localparam int IDW    = idx_width(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH_A-1:0]   req_a,
  input  logic [N_REQ*WIDTH_B-1:0]   req_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH_O-1:0]  out_data,
  output logic [IDW-1:0]             out_id,
  output logic                       busy
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int SH = align_shift(EXP_A, EXP_B, EXP_O);
  // Left alignment needs headroom so no product bits are lost before narrowing.
  localparam int AW = (SH < 0) ? PW - SH : PW;
  localparam int NW = (AW > WIDTH_O) ? AW : WIDTH_O;

`ifdef SVREAL_MUL_ARB_SAT_EN
  localparam logic signed [NW-1:0] SAT_MAX_V = NW'(sat_max(WIDTH_O));
  localparam logic signed [NW-1:0] SAT_MIN_V = NW'(sat_min(WIDTH_O));
`endif

  // Bring the full product onto the output exponent (floor on right shift).
  function automatic logic signed [AW-1:0] align_f(input logic signed [PW-1:0] p);
    logic signed [AW-1:0] x;
    x = AW'(p);
    if (SH > 0)
      x = x >>> SH;
    else if (SH < 0)
      x = x <<< (-SH);
    return x;
  endfunction

  // Narrow to WIDTH_O: clamp when saturation is built in, otherwise wrap.
  function automatic logic signed [WIDTH_O-1:0] narrow_f(input logic signed [AW-1:0] x);
    logic signed [NW-1:0] y;
    y = NW'(x);
`ifdef SVREAL_MUL_ARB_SAT_EN
    if (y > SAT_MAX_V)
      y = SAT_MAX_V;
    else if (y < SAT_MIN_V)
      y = SAT_MIN_V;
`endif
    return y[WIDTH_O-1:0];
  endfunction

  logic [IDW-1:0]             ptr;
  logic [N_REQ-1:0]           grant;
  logic [IDW-1:0]             grant_idx;
  logic                       grant_valid;
  logic                       advance;
  logic                       accept_ok;
  logic                       accept;
  logic signed [WIDTH_A-1:0]  a_sel;
  logic signed [WIDTH_B-1:0]  b_sel;

  logic                       vld_p1;
  logic signed [WIDTH_A-1:0]  a_p1;
  logic signed [WIDTH_B-1:0]  b_p1;
  logic [IDW-1:0]             id_p1;
  logic signed [PW-1:0]       prod_p1;

  logic                       vld_p2;
  logic signed [WIDTH_O-1:0]  dat_p2;
  logic [IDW-1:0]             id_p2;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The output register frees up when empty or drained this cycle; S1 can
  // then refill in the same cycle so back-to-back requests see no bubble.
  assign advance   = !vld_p2 || out_ready;
  assign accept_ok = !vld_p1 || advance;
  assign accept    = grant_valid && accept_ok;
  assign req_ready = accept ? grant : '0;

  // Route the granted requester's operands toward S1.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH_A +: WIDTH_A];
        b_sel = req_b[i*WIDTH_B +: WIDTH_B];
      end
    end
  end

  // Stage valids and round-robin pointer; pointer only moves on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ptr    <= IDW'(N_REQ - 1);
    end else begin
      if (accept_ok)
        vld_p1 <= accept;
      if (advance)
        vld_p2 <= vld_p1;
      if (accept)
        ptr <= grant_idx;
    end
  end

  // ---- stage p1: registered operands and requester id ----
  // Operand capture on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= a_sel;
      b_p1  <= b_sel;
      id_p1 <= grant_idx;
    end
  end

  assign prod_p1 = a_p1 * b_p1;

  // ---- stage p2: aligned, narrowed product (output register) ----
  // Result register loads when it can move and S1 holds a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_p2 <= '0;
      id_p2  <= '0;
    end else if (advance && vld_p1) begin
      dat_p2 <= narrow_f(align_f(prod_p1));
      id_p2  <= id_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = dat_p2;
  assign out_id    = id_p2;
  assign busy      = vld_p1 || vld_p2;

endmodule
